// File: rtl/dist_fifo_pkg.sv
// dist_fifo_pkg: shared defaults for the distributed-RAM FIFO.
// Holds the data/address width defaults, the occupancy-flag threshold
// defaults and a helper that turns an address width into a depth.
package dist_fifo_pkg;

   localparam int DW_DEF        = 16;
   localparam int AW_DEF        = 6;
   localparam int AFULL_TH_DEF  = 60;
   localparam int AEMPTY_TH_DEF = 4;

   // Number of entries addressed by an aw-bit RAM address.
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/dist_ram.sv
// dist_ram: distributed (LUT) RAM, synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps onto LUT RAM.
module dist_ram #(
   parameter int DW = 16,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem [(1<<AW)];

   // Store one word per enabled clock edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   assign rd = mem[ra];

endmodule

// File: rtl/dist_fifo.sv
// dist_fifo: parametrised synchronous FIFO over a distributed RAM.
// Pointers are AW+1 bits so wrap-around is unambiguous; occupancy is kept
// in its own count register and all flags decode that register only, so
// there is no combinational path from wr_en/rd_en to any flag.
// Build option: define DIST_FIFO_FWFT_EN for first-word-fall-through reads
// (head word shown combinationally, rd_en pops it). Without it, a popped
// word is registered onto rd_data for one cycle with rd_valid.
module dist_fifo
   import dist_fifo_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int AW        = AW_DEF,
   parameter int AFULL_TH  = AFULL_TH_DEF,
   parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam int          DEPTH    = depth_of(AW);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);
   localparam logic [AW:0] ONE_C    = (AW+1)'(1);

   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          wr_acc, rd_acc;
   logic          ram_we;
   logic [DW-1:0] ram_rd;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A full FIFO still accepts a read and an empty one still accepts a
   // write; only the request that cannot be honoured is rejected.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Requests arriving in a reset cycle must not touch the array either.
   assign ram_we = wr_acc && rstn;

   dist_ram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk (clk),
      .we  (ram_we),
      .wa  (wptr_q[AW-1:0]),
      .wd  (wr_data),
      .ra  (rptr_q[AW-1:0]),
      .rd  (ram_rd)
   );

   // Pointer, occupancy and error-pulse next state.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
      if (wr_acc) begin
         wptr_d = wptr_q + ONE_C;
      end
      if (rd_acc) begin
         rptr_d = rptr_q + ONE_C;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and error-pulse registers; reset wins over requests.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef DIST_FIFO_FWFT_EN

   // Head word falls through; rd_data is meaningless while empty.
   assign rd_data  = ram_rd;
   assign rd_valid = !empty;

`else

   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;

   // Capture the popped word; rd_data holds it until the next pop.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) begin
         rd_data_d = ram_rd;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

`endif

endmodule
